// File: rtl/pipe_controller.sv
// Pipeline control for a 5-stage MIPS-style core: ID decode, ID/EX/MEM/WB control
// registers, load-use stall, multi-cycle multiply hold and taken-branch flush.
module pipe_controller #(
  parameter int MUL_LAT = 3,
  parameter int RA_W    = 5
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic [5:0]      Opcode,
  input  logic [5:0]      Funct,
  input  logic [RA_W-1:0] BrRt,
  input  logic [RA_W-1:0] ID_Rs,
  input  logic [RA_W-1:0] ID_Rt,
  input  logic [RA_W-1:0] ID_Rd,
  input  logic            BranchTaken,
  output logic            PCWrite,
  output logic            IFIDWrite,
  output logic            EX_RegWrite,
  output logic            EX_MemRead,
  output logic            EX_MemWrite,
  output logic            EX_MemToReg,
  output logic            EX_RegDst,
  output logic            EX_PCSrc,
  output logic [1:0]      EX_ALUSrc1,
  output logic [1:0]      EX_Width,
  output logic [3:0]      EX_InstrSel,
  output logic [RA_W-1:0] EX_Dest,
  output logic            MEM_RegWrite,
  output logic            MEM_MemRead,
  output logic            MEM_MemWrite,
  output logic            MEM_MemToReg,
  output logic [1:0]      MEM_Width,
  output logic            WB_RegWrite,
  output logic            WB_MemToReg,
  output logic            Busy
);

  typedef struct packed {
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            reg_dst;
    logic            pc_src;
    logic            is_mul;
    logic [1:0]      alu_src1;
    logic [1:0]      width;
    logic [3:0]      instr_sel;
    logic [RA_W-1:0] dest;
  } ctrl_t;

  typedef enum logic [1:0] {RUN, LDSTALL, MULWAIT} state_t;

  state_t     state;
  state_t     mode;
  ctrl_t      dec;
  ctrl_t      ex;
  logic [3:0] cnt;
  logic       known;
  logic       flush;
  logic       hazard;

  // ALUSrc1: 0 register, 1 sign/zero-extended immediate, 2 return-address link
  always_comb begin
    dec   = '0;
    known = 1'b1;
    case (Opcode)
      6'h00: begin
        if (Funct == 6'h08) begin
          dec.pc_src    = 1'b1;
          dec.instr_sel = 4'd7;
        end else begin
          dec.reg_write = 1'b1;
          dec.reg_dst   = 1'b1;
        end
      end
      6'h1C: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 1'b1;
        dec.is_mul    = 1'b1;
      end
      6'h23, 6'h21, 6'h20: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src1   = 2'd1;
        dec.width      = (Opcode == 6'h23) ? 2'd0 : (Opcode == 6'h21) ? 2'd1 : 2'd2;
      end
      6'h2B, 6'h29, 6'h28: begin
        dec.mem_write = 1'b1;
        dec.alu_src1  = 2'd1;
        dec.width     = (Opcode == 6'h2B) ? 2'd0 : (Opcode == 6'h29) ? 2'd1 : 2'd2;
      end
      6'h04: begin dec.pc_src = 1'b1; dec.instr_sel = 4'd1; end
      6'h05: begin dec.pc_src = 1'b1; dec.instr_sel = 4'd2; end
      6'h07: begin dec.pc_src = 1'b1; dec.instr_sel = 4'd3; end
      6'h06: begin dec.pc_src = 1'b1; dec.instr_sel = 4'd4; end
      6'h01: begin
        if (BrRt == '0) begin
          dec.pc_src    = 1'b1;
          dec.instr_sel = 4'd5;
        end else if (BrRt == RA_W'(1)) begin
          dec.pc_src    = 1'b1;
          dec.instr_sel = 4'd0;
        end else begin
          known = 1'b0;
        end
      end
      6'h02: begin dec.pc_src = 1'b1; dec.instr_sel = 4'd6; end
      6'h03: begin
        dec.pc_src    = 1'b1;
        dec.reg_write = 1'b1;
        dec.instr_sel = 4'd8;
        dec.alu_src1  = 2'd2;
      end
      6'h08, 6'h0D, 6'h0E, 6'h0A: begin
        dec.reg_write = 1'b1;
        dec.alu_src1  = 2'd1;
      end
      default: known = 1'b0;
    endcase
    if (!known)                dec      = '0;
    else if (dec.reg_dst)      dec.dest = ID_Rd;
    else if (Opcode == 6'h03)  dec.dest = RA_W'(31);
    else                       dec.dest = ID_Rt;
  end

  // A taken branch wins over the load-use check; neither is honoured during a multiply hold.
  always_comb begin
    flush  = (state == RUN) && BranchTaken && ex.pc_src;
    hazard = (state == RUN) && !flush && ex.mem_read && (ex.dest != '0) &&
             ((ex.dest == ID_Rs) || (ex.dest == ID_Rt));
    if (state == MULWAIT) mode = MULWAIT;
    else if (hazard)      mode = LDSTALL;
    else                  mode = RUN;
  end

  assign Busy        = (mode != RUN);
  assign PCWrite     = (mode == RUN);
  assign IFIDWrite   = (mode == RUN);
  assign EX_RegWrite = ex.reg_write;
  assign EX_MemRead  = ex.mem_read;
  assign EX_MemWrite = ex.mem_write;
  assign EX_MemToReg = ex.mem_to_reg;
  assign EX_RegDst   = ex.reg_dst;
  assign EX_PCSrc    = ex.pc_src;
  assign EX_ALUSrc1  = ex.alu_src1;
  assign EX_Width    = ex.width;
  assign EX_InstrSel = ex.instr_sel;
  assign EX_Dest     = ex.dest;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= RUN;
      cnt          <= '0;
      ex           <= '0;
      MEM_RegWrite <= 1'b0;
      MEM_MemRead  <= 1'b0;
      MEM_MemWrite <= 1'b0;
      MEM_MemToReg <= 1'b0;
      MEM_Width    <= 2'd0;
      WB_RegWrite  <= 1'b0;
      WB_MemToReg  <= 1'b0;
    end else begin
      WB_RegWrite <= MEM_RegWrite;
      WB_MemToReg <= MEM_MemToReg;
      if (state == MULWAIT) begin
        MEM_RegWrite <= 1'b0;
        MEM_MemRead  <= 1'b0;
        MEM_MemWrite <= 1'b0;
        MEM_MemToReg <= 1'b0;
        MEM_Width    <= 2'd0;
        if (cnt <= 4'd1) begin
          state <= RUN;
          cnt   <= '0;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end else begin
        MEM_RegWrite <= ex.reg_write;
        MEM_MemRead  <= ex.mem_read;
        MEM_MemWrite <= ex.mem_write;
        MEM_MemToReg <= ex.mem_to_reg;
        MEM_Width    <= ex.width;
        if (flush || hazard) begin
          ex <= '0;
        end else begin
          ex <= dec;
          if (dec.is_mul && (MUL_LAT > 1)) begin
            state <= MULWAIT;
            cnt   <= 4'(MUL_LAT - 1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_controller.sv
// Directed and randomized bench for pipe_controller against an instruction-level
// reference model (opcode table plus remaining-wait counter).
module tb_pipe_controller;
  localparam int MUL_LAT = 3;
  localparam int RA_W    = 5;
  localparam logic [1:0] DK_RT = 2'd0, DK_RD = 2'd1, DK_31 = 2'd2;

  logic            Clk = 1'b0;
  logic            Rst_n;
  logic [5:0]      Opcode, Funct;
  logic [RA_W-1:0] BrRt, ID_Rs, ID_Rt, ID_Rd;
  logic            BranchTaken;
  logic            PCWrite, IFIDWrite, Busy;
  logic            EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_RegDst, EX_PCSrc;
  logic [1:0]      EX_ALUSrc1, EX_Width;
  logic [3:0]      EX_InstrSel;
  logic [RA_W-1:0] EX_Dest;
  logic            MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_MemToReg;
  logic [1:0]      MEM_Width;
  logic            WB_RegWrite, WB_MemToReg;

  pipe_controller #(.MUL_LAT(MUL_LAT), .RA_W(RA_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Opcode(Opcode), .Funct(Funct), .BrRt(BrRt),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .BranchTaken(BranchTaken),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_MemToReg(EX_MemToReg), .EX_RegDst(EX_RegDst), .EX_PCSrc(EX_PCSrc),
    .EX_ALUSrc1(EX_ALUSrc1), .EX_Width(EX_Width), .EX_InstrSel(EX_InstrSel), .EX_Dest(EX_Dest),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_MemToReg(MEM_MemToReg), .MEM_Width(MEM_Width),
    .WB_RegWrite(WB_RegWrite), .WB_MemToReg(WB_MemToReg), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       ok, rw, mr, mw, m2r, rdst, pcs, mul;
    logic [1:0] src, wid;
    logic [3:0] sel;
    logic [1:0] dk;
    logic [4:0] dest;
  } bun_t;

  bun_t optab [64];
  bun_t rtype, jr, bltz, bgez;
  bun_t m_ex, m_mem, m_wb;
  int   wait_left;
  bit   last_stall;
  logic pcw_seen, busy_seen;
  int   passed = 0;
  int   total  = 0;

  logic [18:0] dut_ex;
  logic [7:0]  dut_mw;
  assign dut_ex = {EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_RegDst, EX_PCSrc,
                   EX_ALUSrc1, EX_Width, EX_InstrSel, EX_Dest};
  assign dut_mw = {MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_MemToReg, MEM_Width,
                   WB_RegWrite, WB_MemToReg};

  function automatic bun_t mk(bit rw, bit mr, bit mw, bit m2r, bit rdst, bit pcs, bit mul,
                              logic [1:0] src, logic [1:0] wid, logic [3:0] sel, logic [1:0] dk);
    bun_t b;
    b = '0;
    b.ok = 1'b1; b.rw = rw; b.mr = mr; b.mw = mw; b.m2r = m2r; b.rdst = rdst;
    b.pcs = pcs; b.mul = mul; b.src = src; b.wid = wid; b.sel = sel; b.dk = dk;
    return b;
  endfunction

  task automatic build_table();
    for (int i = 0; i < 64; i++) optab[i] = '0;
    rtype       = mk(1,0,0,0,1,0,0, 2'd0, 2'd0, 4'd0, DK_RD);
    jr          = mk(0,0,0,0,0,1,0, 2'd0, 2'd0, 4'd7, DK_RT);
    bltz        = mk(0,0,0,0,0,1,0, 2'd0, 2'd0, 4'd5, DK_RT);
    bgez        = mk(0,0,0,0,0,1,0, 2'd0, 2'd0, 4'd0, DK_RT);
    optab['h1C] = mk(1,0,0,0,1,0,1, 2'd0, 2'd0, 4'd0, DK_RD);
    optab['h23] = mk(1,1,0,1,0,0,0, 2'd1, 2'd0, 4'd0, DK_RT);
    optab['h21] = mk(1,1,0,1,0,0,0, 2'd1, 2'd1, 4'd0, DK_RT);
    optab['h20] = mk(1,1,0,1,0,0,0, 2'd1, 2'd2, 4'd0, DK_RT);
    optab['h2B] = mk(0,0,1,0,0,0,0, 2'd1, 2'd0, 4'd0, DK_RT);
    optab['h29] = mk(0,0,1,0,0,0,0, 2'd1, 2'd1, 4'd0, DK_RT);
    optab['h28] = mk(0,0,1,0,0,0,0, 2'd1, 2'd2, 4'd0, DK_RT);
    optab['h04] = mk(0,0,0,0,0,1,0, 2'd0, 2'd0, 4'd1, DK_RT);
    optab['h05] = mk(0,0,0,0,0,1,0, 2'd0, 2'd0, 4'd2, DK_RT);
    optab['h07] = mk(0,0,0,0,0,1,0, 2'd0, 2'd0, 4'd3, DK_RT);
    optab['h06] = mk(0,0,0,0,0,1,0, 2'd0, 2'd0, 4'd4, DK_RT);
    optab['h02] = mk(0,0,0,0,0,1,0, 2'd0, 2'd0, 4'd6, DK_RT);
    optab['h03] = mk(1,0,0,0,0,1,0, 2'd2, 2'd0, 4'd8, DK_31);
    optab['h08] = mk(1,0,0,0,0,0,0, 2'd1, 2'd0, 4'd0, DK_RT);
    optab['h0D] = mk(1,0,0,0,0,0,0, 2'd1, 2'd0, 4'd0, DK_RT);
    optab['h0E] = mk(1,0,0,0,0,0,0, 2'd1, 2'd0, 4'd0, DK_RT);
    optab['h0A] = mk(1,0,0,0,0,0,0, 2'd1, 2'd0, 4'd0, DK_RT);
  endtask

  function automatic bun_t ref_decode(logic [5:0] op, logic [5:0] fn,
                                      logic [4:0] rt, logic [4:0] rd);
    bun_t b;
    if (op == 6'h00)      b = (fn == 6'h08) ? jr : rtype;
    else if (op == 6'h01) b = (rt == 5'd0) ? bltz : (rt == 5'd1) ? bgez : '0;
    else                  b = optab[op];
    if (!b.ok) return '0;
    b.dest = (b.dk == DK_RD) ? rd : (b.dk == DK_31) ? 5'd31 : rt;
    return b;
  endfunction

  function automatic logic [18:0] ex_of(bun_t b);
    return {b.rw, b.mr, b.mw, b.m2r, b.rdst, b.pcs, b.src, b.wid, b.sel, b.dest};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; wait_left = 0; last_stall = 1'b0;
  endtask

  task automatic set_id(logic [5:0] op, logic [5:0] fn, logic [4:0] rs, logic [4:0] rt,
                        logic [4:0] rd);
    Opcode = op; Funct = fn; ID_Rs = rs; ID_Rt = rt; BrRt = rt; ID_Rd = rd;
  endtask

  // Entered and left at 1 time unit after a rising edge; samples 4 units after it.
  task automatic cycle();
    bit   mulw, fl, hz;
    bun_t d;
    #3;
    mulw = (wait_left > 0);
    fl   = !mulw && BranchTaken && m_ex.pcs;
    hz   = !mulw && !fl && m_ex.mr && (m_ex.dest != 5'd0) &&
           ((m_ex.dest == ID_Rs) || (m_ex.dest == ID_Rt));
    last_stall = mulw || hz;
    pcw_seen   = PCWrite;
    busy_seen  = Busy;
    chk("ctl", 32'({Busy, PCWrite, IFIDWrite}), 32'({last_stall, !last_stall, !last_stall}));
    chk("ex", 32'(dut_ex), 32'(ex_of(m_ex)));
    chk("memwb", 32'(dut_mw),
        32'({m_mem.rw, m_mem.mr, m_mem.mw, m_mem.m2r, m_mem.wid, m_wb.rw, m_wb.m2r}));
    d = ref_decode(Opcode, Funct, ID_Rt, ID_Rd);
    @(posedge Clk);
    m_wb = m_mem;
    if (mulw) begin
      m_mem = '0;
      wait_left--;
    end else begin
      m_mem = m_ex;
      m_ex  = (fl || hz) ? '0 : d;
      if (!fl && !hz && d.mul) wait_left = MUL_LAT - 1;
    end
    #1;
  endtask

  logic [5:0] pool [20] = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                            6'h08, 6'h0A, 6'h0D, 6'h0E, 6'h1C, 6'h20, 6'h21, 6'h23, 6'h28,
                            6'h2B, 6'h3F};

  initial begin
    build_table();
    model_reset();
    set_id(6'h00, 6'h20, 5'd0, 5'd0, 5'd0);
    BranchTaken = 1'b0;
    Rst_n = 1'b1;
    #1 Rst_n = 1'b0;
    #2;
    chk("rst_ex", 32'(dut_ex), 32'd0);
    chk("rst_memwb", 32'(dut_mw), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    @(posedge Clk); #1 Rst_n = 1'b1;

    // load-use: lw $8 ; add $9,$8,$1
    set_id(6'h23, 6'h00, 5'd1, 5'd8, 5'd0); cycle();
    set_id(6'h00, 6'h20, 5'd8, 5'd1, 5'd9); cycle();
    chk("ldu_pcwrite", 32'(pcw_seen), 32'd0);
    chk("ldu_ex_bubble", 32'(dut_ex), 32'd0);
    cycle();
    chk("ldu_pcwrite_resume", 32'(pcw_seen), 32'd1);
    chk("ldu_add_dest", 32'(EX_Dest), 32'd9);
    chk("ldu_wb_lw", 32'(WB_MemToReg), 32'd1);
    set_id(6'h08, 6'h00, 5'd1, 5'd2, 5'd0); cycle();
    chk("ldu_wb_bubble", 32'(WB_MemToReg), 32'd0);

    // lw $0 followed by a $0 consumer does not stall
    set_id(6'h23, 6'h00, 5'd1, 5'd0, 5'd0); cycle();
    set_id(6'h00, 6'h20, 5'd0, 5'd0, 5'd9); cycle();
    chk("lw0_nostall", 32'(pcw_seen), 32'd1);

    // mul holds EX for MUL_LAT cycles
    set_id(6'h1C, 6'h02, 5'd1, 5'd2, 5'd10); cycle();
    chk("mul_busy_now", 32'(Busy), 32'd1);
    set_id(6'h08, 6'h00, 5'd1, 5'd3, 5'd0);
    cycle(); chk("mul_busy_1", 32'(busy_seen), 32'd1);
    cycle(); chk("mul_busy_2", 32'(busy_seen), 32'd1);
    chk("mul_ex_hold", 32'(EX_Dest), 32'd10);
    chk("mul_mem_bubble", 32'(MEM_RegWrite), 32'd0);
    cycle(); chk("mul_busy_done", 32'(busy_seen), 32'd0);
    chk("mul_next_ex", 32'(EX_Dest), 32'd3);
    chk("mul_in_mem", 32'(MEM_RegWrite), 32'd1);

    // taken branch flushes the following ID/EX load
    set_id(6'h04, 6'h00, 5'd1, 5'd2, 5'd0); cycle();
    set_id(6'h00, 6'h20, 5'd8, 5'd1, 5'd9); BranchTaken = 1'b1; cycle();
    BranchTaken = 1'b0;
    chk("flush_pcwrite", 32'(pcw_seen), 32'd1);
    chk("flush_bubble", 32'(dut_ex), 32'd0);

    // jal and an undefined opcode
    set_id(6'h03, 6'h00, 5'd0, 5'd0, 5'd0); cycle();
    chk("jal_dest", 32'(EX_Dest), 32'd31);
    chk("jal_regwrite", 32'(EX_RegWrite), 32'd1);
    chk("jal_sel", 32'(EX_InstrSel), 32'd8);
    set_id(6'h3F, 6'h20, 5'd1, 5'd2, 5'd3); cycle();
    chk("badop_ex", 32'(dut_ex), 32'd0);

    // asynchronous reset in the first multiply wait cycle
    set_id(6'h1C, 6'h02, 5'd1, 5'd2, 5'd10); cycle();
    #1 Rst_n = 1'b0;
    #1;
    chk("arst_ex", 32'(dut_ex), 32'd0);
    chk("arst_memwb", 32'(dut_mw), 32'd0);
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_pcwrite", 32'(PCWrite), 32'd1);
    model_reset();
    @(posedge Clk); #1 Rst_n = 1'b1;
    set_id(6'h08, 6'h00, 5'd1, 5'd3, 5'd0); cycle();
    chk("post_rst_latch", 32'(EX_Dest), 32'd3);

    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        Opcode = pool[$urandom_range(0, 19)];
        Funct  = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'h20;
        ID_Rs  = 5'($urandom_range(0, 3));
        ID_Rt  = 5'($urandom_range(0, 3));
        ID_Rd  = 5'($urandom_range(0, 3));
        BrRt   = ID_Rt;
      end
      BranchTaken = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
